// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC constants and opcodes common to fetch and decode.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Primary opcode field values (instr[31:26]) shared with the decoder.
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_ADDI    = 6'h08;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target computation: branch (link + word offset) or jump (region + word target).
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic        redir_branch,
    input  logic        redir_jump,
    input  logic [31:0] redir_pc,
    input  logic [15:0] beq_off,
    input  logic [25:0] target_addr,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] link;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Jump takes priority; with no redirect the target is simply the link value.
    always_comb begin
        link          = redir_pc + PC_STEP;
        branch_target = link + {{14{beq_off[15]}}, beq_off, 2'b00};
        jump_target   = {link[31:28], target_addr, 2'b00};
        if (redir_jump) begin
            target = jump_target;
        end else if (redir_branch) begin
            target = branch_target;
        end else begin
            target = link;
        end
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory (one outstanding request) and hands
// instructions to decode. Optional misaligned-redirect trap enabled by IF_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus4,
    input  logic              redir_branch,
    input  logic              redir_jump,
    input  logic [DATA_W-1:0] redir_pc,
    input  logic [15:0]       beq_off,
    input  logic [25:0]       target_addr,
    output logic              fetch_err
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [DATA_W-1:0] fetch_pc;
    logic              kill;
    logic [31:0]       calc_target;
    logic              calc_misaligned;
    logic [DATA_W-1:0] redirect_target;
    logic              redirect_take;

    next_pc_calc u_next_pc_calc (
        .redir_branch (redir_branch),
        .redir_jump   (redir_jump),
        .redir_pc     (redir_pc),
        .beq_off      (beq_off),
        .target_addr  (target_addr),
        .target       (calc_target),
        .misaligned   (calc_misaligned)
    );

    assign redirect_take = (redir_branch || redir_jump) && (state != HALT);

`ifdef IF_MISALIGN_TRAP_EN
    logic trap_redirect;
    assign redirect_target = calc_target;
    assign trap_redirect   = redirect_take && calc_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err <= 1'b0;
        end else if (trap_redirect) begin
            fetch_err <= 1'b1;
        end
    end
`else
    logic unused_calc;
    assign redirect_target = {calc_target[31:2], 2'b00};
    assign unused_calc     = ^{calc_target[1:0], calc_misaligned};
    assign fetch_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect out of HOLD or a killed/dropped response always returns to REQ.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ:  if (imem_gnt) state_next = WAIT;
            WAIT: if (imem_rvalid) state_next = (kill || redirect_take) ? REQ : HOLD;
            HOLD: if (redirect_take || instr_ready) state_next = REQ;
`ifdef IF_MISALIGN_TRAP_EN
            HALT: state_next = HALT;
`endif
            default: state_next = IDLE;
        endcase
`ifdef IF_MISALIGN_TRAP_EN
        if (trap_redirect) begin
            state_next = HALT;
        end
`endif
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = fetch_pc;
    end

    // A redirect caught with a request in flight marks that response for discard via kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc          <= '0;
            pc_plus4    <= PC_STEP;
        end else if (redirect_take) begin
            fetch_pc    <= redirect_target;
            instr_valid <= 1'b0;
            if (state == WAIT) begin
                kill <= !imem_rvalid;
            end else if ((state == REQ) && imem_gnt) begin
                kill <= 1'b1;
            end
        end else if ((state == WAIT) && imem_rvalid) begin
            if (kill) begin
                kill <= 1'b0;
            end else begin
                instr       <= imem_rdata;
                pc          <= fetch_pc;
                pc_plus4    <= fetch_pc + PC_STEP;
                fetch_pc    <= fetch_pc + PC_STEP;
                instr_valid <= 1'b1;
            end
        end else if ((state == HOLD) && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; honours IF_MISALIGN_TRAP_EN when defined.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redir_branch;
    logic        redir_jump;
    logic [31:0] redir_pc;
    logic [15:0] beq_off;
    logic [25:0] target_addr;
    logic        fetch_err;

    int pass_count  = 0;
    int check_count = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .redir_branch (redir_branch),
        .redir_jump   (redir_jump),
        .redir_pc     (redir_pc),
        .beq_off      (beq_off),
        .target_addr  (target_addr),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drive the memory/decode inputs for one cycle, then sample just after the edge.
    task automatic applyStimulus(input logic gnt, input logic rvalid,
                                 input logic [31:0] rdata, input logic ready);
        imem_gnt    = gnt;
        imem_rvalid = rvalid;
        imem_rdata  = rdata;
        instr_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic clearRedirect();
        redir_branch = 1'b0;
        redir_jump   = 1'b0;
        redir_pc     = '0;
        beq_off      = '0;
        target_addr  = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        clearRedirect();

        applyStimulus(0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("rst_req",      {31'b0, imem_req},    32'h0);
        checkOutput("rst_valid",    {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_instr",    instr,                32'h0);
        checkOutput("rst_pc",       pc,                   32'h0);
        checkOutput("rst_pc_plus4", pc_plus4,             32'h4);
        checkOutput("rst_err",      {31'b0, fetch_err},   32'h0);

        // T1: first fetch, gnt same cycle, rvalid next cycle
        rst_n = 1'b1;
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("t1_req",  {31'b0, imem_req}, 32'h1);
        checkOutput("t1_addr", imem_addr,         32'h0);
        applyStimulus(1, 0, 32'h0, 0);
        checkOutput("t1_wait_req", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 1, 32'h2009_0005, 1);
        checkOutput("t1_valid",  {31'b0, instr_valid}, 32'h1);
        checkOutput("t1_instr",  instr,                32'h2009_0005);
        checkOutput("t1_pc",     pc,                   32'h0);
        checkOutput("t1_plus4",  pc_plus4,             32'h4);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("t1_consumed", {31'b0, instr_valid}, 32'h0);
        checkOutput("t1_next_req", {31'b0, imem_req},    32'h1);
        checkOutput("t1_next_addr", imem_addr,           32'h4);

        // T2: decode stalls five cycles in HOLD
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'hAAAA_0001, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 32'h0, 0);
            checkOutput("t2_valid", {31'b0, instr_valid}, 32'h1);
            checkOutput("t2_instr", instr,                32'hAAAA_0001);
            checkOutput("t2_pc",    pc,                   32'h4);
            checkOutput("t2_req",   {31'b0, imem_req},    32'h0);
        end
        checkOutput("t2_plus4", pc_plus4, 32'h8);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("t2_next_addr", imem_addr, 32'h8);

        // T3: taken branch while a read is in flight
        applyStimulus(1, 0, 32'h0, 0);
        redir_branch = 1'b1;
        redir_pc     = 32'h40;
        beq_off      = 16'hFFFE;
        applyStimulus(0, 0, 32'h0, 0);
        clearRedirect();
        checkOutput("t3_still_wait", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 1);
        checkOutput("t3_dropped", {31'b0, instr_valid}, 32'h0);
        checkOutput("t3_req",     {31'b0, imem_req},    32'h1);
        checkOutput("t3_addr",    imem_addr,            32'h3C);
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h1111_2222, 0);
        checkOutput("t3_instr", instr,    32'h1111_2222);
        checkOutput("t3_pc",    pc,       32'h3C);
        checkOutput("t3_plus4", pc_plus4, 32'h40);

        // T4: jump and branch together in HOLD with ready high; jump wins, redirect beats ready
        redir_jump   = 1'b1;
        redir_branch = 1'b1;
        redir_pc     = 32'h1000_0010;
        beq_off      = 16'hFFFE;
        target_addr  = 26'h40;
        applyStimulus(0, 0, 32'h0, 1);
        clearRedirect();
        checkOutput("t4_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("t4_req",   {31'b0, imem_req},    32'h1);
        checkOutput("t4_addr",  imem_addr,            32'h1000_0100);

        // T5: grant withheld four cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 32'h0, 0);
            checkOutput("t5_req",  {31'b0, imem_req}, 32'h1);
            checkOutput("t5_addr", imem_addr,         32'h1000_0100);
        end
        applyStimulus(1, 0, 32'h0, 0);
        checkOutput("t5_granted", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 1, 32'h3333_4444, 1);
        checkOutput("t5_pc",    pc,       32'h1000_0100);
        checkOutput("t5_plus4", pc_plus4, 32'h1000_0104);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("t5_next_addr", imem_addr, 32'h1000_0104);

        // T6: branch producing misaligned target 32'h2
        redir_branch = 1'b1;
        redir_pc     = 32'h2;
        beq_off      = 16'hFFFF;
        applyStimulus(0, 0, 32'h0, 0);
        clearRedirect();
`ifdef IF_MISALIGN_TRAP_EN
        checkOutput("t6_err", {31'b0, fetch_err}, 32'h1);
        checkOutput("t6_req", {31'b0, imem_req},  32'h0);
        redir_jump  = 1'b1;
        redir_pc    = 32'h100;
        target_addr = 26'h10;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 32'h5555_5555, 1);
            checkOutput("t6_halt_req",   {31'b0, imem_req},    32'h0);
            checkOutput("t6_halt_valid", {31'b0, instr_valid}, 32'h0);
            checkOutput("t6_sticky",     {31'b0, fetch_err},   32'h1);
        end
        clearRedirect();
`else
        checkOutput("t6_err",  {31'b0, fetch_err}, 32'h0);
        checkOutput("t6_req",  {31'b0, imem_req},  32'h1);
        checkOutput("t6_addr", imem_addr,          32'h0);
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h2009_0005, 0);
        checkOutput("t6_pc",    pc,       32'h0);
        checkOutput("t6_instr", instr,    32'h2009_0005);
`endif

        // Asynchronous reset mid-operation clears outputs immediately
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("mid_rst_req",   {31'b0, imem_req},    32'h0);
        checkOutput("mid_rst_plus4", pc_plus4,             32'h4);
        checkOutput("mid_rst_err",   {31'b0, fetch_err},   32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
